fm_phase_inc_gen: RTL and testbench



---
 rtl/fm_phase_inc_gen.sv | 104 ++++++++++
 tb/tb_fm_phase_inc_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fm_phase_inc_gen.sv
// fm_phase_inc_gen: scales audio by a deviation gain, adds the carrier increment and hands a clamped increment to the DDS on its enable strobe.
// Define FM_DITHER_EN to add 4-bit LFSR dither to the increment before the clamp.
module fm_phase_inc_gen #(
    parameter int NBITS_PHASE = 13,
    parameter int GAIN_SHIFT  = 8,
    parameter int CLKDIV      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        carrier_inc,
    input  logic [15:0]        dev_gain,
    input  logic signed [15:0] audio_in,
    input  logic               audio_valid,
    output logic               audio_ready,
    output logic               enableclk,
    output logic [31:0]        phaseinc,
    output logic               overflow
);
    localparam int DW = $clog2(CLKDIV);
    localparam logic signed [33:0] PMAX = (34'sd1 <<< NBITS_PHASE) - 34'sd1;
    typedef enum logic [1:0] {IDLE, MULT, ADD, WAIT_EN} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [15:0] gain;
    logic [3:0] step;
    logic signed [32:0] acc, mcand, scaled;
    logic signed [33:0] sum;
    logic [NBITS_PHASE-1:0] result, clamped;
    logic sat;
    always_ff @(posedge clock) begin
        if (reset) begin
            div       <= '0;
            enableclk <= 1'b0;
        end else begin
            div       <= (div == DW'(CLKDIV - 1)) ? '0 : div + DW'(1);
            enableclk <= (div == DW'(CLKDIV - 1));
        end
    end
    assign scaled = acc >>> GAIN_SHIFT;
`ifdef FM_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (enableclk)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    assign sum = $signed({2'b00, carrier_inc}) + $signed({scaled[32], scaled}) + $signed({30'd0, lfsr[3:0]});
`else
    assign sum = $signed({2'b00, carrier_inc}) + $signed({scaled[32], scaled});
`endif
    assign sat     = (sum < 0) || (sum > PMAX);
    assign clamped = (sum < 0) ? '0 : (sum > PMAX) ? '1 : sum[NBITS_PHASE-1:0];
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            audio_ready <= 1'b0;
            phaseinc    <= '0;
            overflow    <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            gain        <= '0;
            step        <= '0;
            result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    audio_ready <= 1'b1;
                    if (audio_valid && audio_ready) begin
                        mcand       <= {{17{audio_in[15]}}, audio_in};
                        gain        <= dev_gain;
                        acc         <= '0;
                        step        <= '0;
                        audio_ready <= 1'b0;
                        state       <= MULT;
                    end
                end
                MULT: begin
                    // one gain bit per cycle, LSB first
                    if (gain[0])
                        acc <= acc + mcand;
                    mcand <= mcand <<< 1;
                    gain  <= gain >> 1;
                    step  <= step + 4'd1;
                    if (step == 4'd15)
                        state <= ADD;
                end
                ADD: begin
                    result   <= clamped;
                    overflow <= overflow | sat;
                    state    <= WAIT_EN;
                end
                WAIT_EN: begin
                    if (enableclk) begin
                        phaseinc    <= 32'(result);
                        audio_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_phase_inc_gen.sv
// tb_fm_phase_inc_gen: directed checks of fm_phase_inc_gen timing, scaling, saturation and reset abort.
module tb_fm_phase_inc_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] carrier_inc = '0;
    logic [15:0] dev_gain = '0;
    logic signed [15:0] audio_in = '0;
    logic audio_valid = 1'b0;
    logic audio_ready, enableclk, overflow;
    logic [31:0] phaseinc;
    int checks = 0;
    int errors = 0;
    int cyc = -1;
    int n, hs, upd, upd1, hs2;

    fm_phase_inc_gen dut (
        .clock(clock), .reset(reset), .carrier_inc(carrier_inc), .dev_gain(dev_gain),
        .audio_in(audio_in), .audio_valid(audio_valid), .audio_ready(audio_ready),
        .enableclk(enableclk), .phaseinc(phaseinc), .overflow(overflow)
    );

    always #5 clock = ~clock;
    // edge index since reset release; edges that see the strobe are multiples of 32
    always @(posedge clock) cyc <= reset ? -1 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!enableclk && cnt < 100);
    endtask

    task automatic wait_ready(output int edge_idx);
        int k = 0;
        while (!audio_ready && k < 200) begin
            @(negedge clock);
            k++;
        end
        edge_idx = cyc;
    endtask

    task automatic send(input string tag, input logic [31:0] car, input logic [15:0] g,
                        input logic signed [15:0] a, input logic [31:0] exp_pi, input logic exp_ov);
        int h, u;
        carrier_inc = car;
        dev_gain    = g;
        audio_in    = a;
        audio_valid = 1'b1;
        @(negedge clock);
        h = cyc;
        audio_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, audio_ready}, 32'd0);
        wait_ready(u);
        check({tag, "_edge"}, u, ((h + 18 + 31) / 32) * 32);
        check({tag, "_pi"}, phaseinc, exp_pi);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, audio_ready}, 32'd0);
        check("rst_en", {31'd0, enableclk}, 32'd0);
        check("rst_pi", phaseinc, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", {31'd0, audio_ready}, 32'd1);
        wait_strobe(n);
        check("first_strobe", n + 1, 32);
        wait_strobe(n);
        check("strobe_period", n, 32);
        check("idle_pi", phaseinc, 32'd0);
        @(negedge clock);
        check("strobe_width", {31'd0, enableclk}, 32'd0);

        send("s100", 32'd2048, 16'd256, 16'sd100, 32'd2148, 1'b0);
        send("s1000", 32'd2048, 16'd300, 16'sd1000, 32'd3219, 1'b0);
        send("neg_sat", 32'd2048, 16'd256, -16'sd3000, 32'd0, 1'b1);
        send("sticky", 32'd2048, 16'd1, -16'sd1, 32'd2047, 1'b1);
        send("pos_sat", 32'd2048, 16'd65535, 16'sd32767, 32'd8191, 1'b1);

        carrier_inc = 32'd2048;
        dev_gain    = 16'd256;
        audio_in    = 16'sd100;
        audio_valid = 1'b1;
        @(negedge clock);
        hs = cyc;
        check("b2b_busy1", {31'd0, audio_ready}, 32'd0);
        audio_in = -16'sd50;
        wait_ready(upd1);
        check("b2b_edge1", upd1, ((hs + 18 + 31) / 32) * 32);
        check("b2b_pi1", phaseinc, 32'd2148);
        @(negedge clock);
        hs2 = cyc;
        check("b2b_hs2", hs2, upd1 + 1);
        check("b2b_busy2", {31'd0, audio_ready}, 32'd0);
        audio_valid = 1'b0;
        wait_ready(upd);
        check("b2b_edge2", upd, upd1 + 32);
        check("b2b_pi2", phaseinc, 32'd1998);

        carrier_inc = 32'd4000;
        repeat (70) @(negedge clock);
        check("carrier_only", phaseinc, 32'd1998);

        dev_gain    = 16'd256;
        audio_in    = 16'sd100;
        audio_valid = 1'b1;
        @(negedge clock);
        audio_valid = 1'b0;
        check("abort_busy", {31'd0, audio_ready}, 32'd0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_pi", phaseinc, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        check("abort_ready", {31'd0, audio_ready}, 32'd0);
        check("abort_en", {31'd0, enableclk}, 32'd0);
        wait_strobe(n);
        check("abort_strobe", n, 32);
        repeat (40) @(negedge clock);
        check("abort_no_update", phaseinc, 32'd0);
        check("abort_idle_ready", {31'd0, audio_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
